// File: rtl/fpga_test_step_pkg.sv
// ---------------------------------------------------------------------------
// fpga_test_step_pkg
//
// Shared constants for the fpga_test_step multiplier slice.
//
//   MUL_TRUNC / MUL_SAT      : encodings of the SAT_MODE parameter
//   NUM_STAGE_MIN / _MAX     : legal pipeline depth of the multiplier
//   sat_mode_e               : enum view of the SAT_MODE encodings
// ---------------------------------------------------------------------------
package fpga_test_step_pkg;

  // Result handling when the full product does not fit the output width.
  localparam int MUL_TRUNC = 0;  // keep the low dout_WIDTH bits
  localparam int MUL_SAT   = 1;  // clamp to the result-type max / min

  typedef enum logic {
    SAT_TRUNC = 1'b0,
    SAT_CLAMP = 1'b1
  } sat_mode_e;

  // Pipeline depth limits for fpga_test_step_mul_pipe.
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

endpackage : fpga_test_step_pkg

// File: rtl/fpga_test_step_pipe_reg.sv
// ---------------------------------------------------------------------------
// fpga_test_step_pipe_reg
//
// One pipeline slice: a valid bit plus a data word, loaded together when the
// global advance enable is high and held otherwise.
//
// Parameters
//   W         : data width
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears valid and data
//   ce        : advance enable (load when 1, hold when 0)
//   in_valid  : valid bit from the previous slice
//   in_data   : data word from the previous slice
//   out_valid : registered valid bit
//   out_data  : registered data word
// ---------------------------------------------------------------------------
module fpga_test_step_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // NOTE: sequential state uses non-blocking (<=) so every slice samples its
  // predecessor's pre-edge value; blocking here would let data race through
  // several stages in one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the data word is a plain register, not a memory array, so
      // resetting it is cheap and gives a clean 0 on the output after reset.
      out_data  <= '0;
    end else if (ce) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule : fpga_test_step_pipe_reg

// File: rtl/fpga_test_step_mul_pipe.sv
// ---------------------------------------------------------------------------
// fpga_test_step_mul_pipe
//
// Pipelined multiplier with valid/ready handshake, selectable operand
// signedness and truncate-or-saturate result handling.
//
// The full product is formed combinationally at din0_WIDTH+din1_WIDTH bits,
// range-checked against the dout_WIDTH result type, optionally clamped, and
// registered into stage 0. Further stages are pure delay. A single advance
// enable (ce) moves every stage at once, so a stall freezes the whole pipe
// and bubbles stay where they are.
//
// Parameters
//   ID           : instance tag, no functional effect
//   NUM_STAGE    : number of register stages (1..4)
//   din0_WIDTH   : operand 0 width
//   din1_WIDTH   : operand 1 width
//   dout_WIDTH   : result width (2..din0_WIDTH+din1_WIDTH)
//   DIN0_SIGNED  : 1 = din0 is two's complement, 0 = unsigned
//   DIN1_SIGNED  : 1 = din1 is two's complement, 0 = unsigned
//   SAT_MODE     : MUL_TRUNC or MUL_SAT
// Ports
//   ap_clk       : rising-edge clock
//   ap_rst_n     : asynchronous active-low reset
//   din_valid    : operand pair valid
//   din_ready    : block accepts operands this cycle (= ce)
//   din0, din1   : operands
//   dout_valid   : result valid
//   dout_ready   : consumer accepts the result
//   dout         : product (truncated or saturated)
//   dout_ovf     : full product did not fit dout_WIDTH (qualified by valid)
// ---------------------------------------------------------------------------
module fpga_test_step_mul_pipe
  import fpga_test_step_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 32,
  parameter int din1_WIDTH  = 8,
  parameter int dout_WIDTH  = 32,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SAT_MODE    = MUL_TRUNC
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  // Full product width; large enough to hold any product exactly for every
  // signedness combination.
  localparam int PW = din0_WIDTH + din1_WIDTH;
  // Stage payload: {ovf, result}.
  localparam int DW = dout_WIDTH + 1;
  // The result is a signed quantity as soon as either operand is signed.
  localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam sat_mode_e MODE = (SAT_MODE == MUL_SAT) ? SAT_CLAMP : SAT_TRUNC;

  // -------------------------------------------------------------------------
  // Full-width product
  // -------------------------------------------------------------------------
  logic [PW-1:0] ext0;
  logic [PW-1:0] ext1;
  logic [PW-1:0] prod;

  // Both operands are extended to PW bits before multiplying. The low PW bits
  // of a PW x PW product are the same for signed and unsigned interpretation,
  // and the exact product always fits PW bits, so prod is exact.
  assign ext0 = (DIN0_SIGNED != 0) ? {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0}
                                   : {{din1_WIDTH{1'b0}}, din0};
  assign ext1 = (DIN1_SIGNED != 0) ? {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1}
                                   : {{din0_WIDTH{1'b0}}, din1};
  assign prod = ext0 * ext1;

  // -------------------------------------------------------------------------
  // Range check and result selection
  // -------------------------------------------------------------------------
  logic                  mul_ovf;
  logic [dout_WIDTH-1:0] mul_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    mul_ovf = 1'b0;
    mul_res = prod[dout_WIDTH-1:0];

    // Signed result fits iff all bits above the output sign bit copy it;
    // unsigned result fits iff all bits above the output MSB are zero.
    for (int i = dout_WIDTH; i < PW; i++) begin
      if (RES_SIGNED) begin
        if (prod[i] != prod[dout_WIDTH-1]) mul_ovf = 1'b1;
      end else begin
        if (prod[i]) mul_ovf = 1'b1;
      end
    end

    if (MODE == SAT_CLAMP && mul_ovf) begin
      if (!RES_SIGNED) begin
        // An unsigned product is never negative, so overflow is always high.
        mul_res = '1;
      end else if (prod[PW-1]) begin
        mul_res = {1'b1, {(dout_WIDTH-1){1'b0}}};
      end else begin
        mul_res = {1'b0, {(dout_WIDTH-1){1'b1}}};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage chain; index 0 is the stage-0 input, NUM_STAGE is the output.
  // -------------------------------------------------------------------------
  logic [NUM_STAGE:0]         stg_valid;
  logic [NUM_STAGE:0][DW-1:0] stg_data;
  logic                       ce;

  // The pipe advances whenever the output slot is empty or being drained.
  assign ce        = dout_ready | ~stg_valid[NUM_STAGE];
  assign din_ready = ce;

  assign stg_valid[0] = din_valid;
  assign stg_data[0]  = {mul_ovf, mul_res};

  for (genvar g = 0; g < NUM_STAGE; g++) begin : g_stage
    fpga_test_step_pipe_reg #(
      .W (DW)
    ) u_reg (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .ce        (ce),
      .in_valid  (stg_valid[g]),
      .in_data   (stg_data[g]),
      .out_valid (stg_valid[g+1]),
      .out_data  (stg_data[g+1])
    );
  end

  assign dout_valid       = stg_valid[NUM_STAGE];
  assign {dout_ovf, dout} = stg_data[NUM_STAGE];

endmodule : fpga_test_step_mul_pipe

// File: tb/tb_fpga_test_step_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpga_test_step_mul_pipe
//
// Four instances share operands and handshake inputs:
//   u_def : default parameters (32x8 -> 32, signed x unsigned, truncate)
//   u_sat : 16-bit result, saturate
//   u_trn : 16-bit result, truncate
//   u_uns : unsigned x unsigned, 32-bit result, saturate
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_fpga_test_step_mul_pipe;

  localparam int N_DIR = 11;
  localparam int N_RND = 100;

  logic        ap_clk     = 1'b0;
  logic        ap_rst_n   = 1'b1;
  logic        din_valid  = 1'b0;
  logic        dout_ready = 1'b1;
  logic [31:0] din0       = '0;
  logic [7:0]  din1       = '0;

  logic        def_rdy, def_vld, def_ovf;
  logic [31:0] def_dout;
  logic        sat_rdy, sat_vld, sat_ovf;
  logic [15:0] sat_dout;
  logic        trn_rdy, trn_vld, trn_ovf;
  logic [15:0] trn_dout;
  logic        uns_rdy, uns_vld, uns_ovf;
  logic [31:0] uns_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  fpga_test_step_mul_pipe u_def (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(def_rdy),
    .din0(din0), .din1(din1), .dout_valid(def_vld), .dout_ready(dout_ready),
    .dout(def_dout), .dout_ovf(def_ovf));

  fpga_test_step_mul_pipe #(.dout_WIDTH(16), .SAT_MODE(1)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(sat_rdy),
    .din0(din0), .din1(din1), .dout_valid(sat_vld), .dout_ready(dout_ready),
    .dout(sat_dout), .dout_ovf(sat_ovf));

  fpga_test_step_mul_pipe #(.dout_WIDTH(16), .SAT_MODE(0)) u_trn (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(trn_rdy),
    .din0(din0), .din1(din1), .dout_valid(trn_vld), .dout_ready(dout_ready),
    .dout(trn_dout), .dout_ovf(trn_ovf));

  fpga_test_step_mul_pipe #(.DIN0_SIGNED(0), .DIN1_SIGNED(0), .SAT_MODE(1)) u_uns (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(uns_rdy),
    .din0(din0), .din1(din1), .dout_valid(uns_vld), .dout_ready(dout_ready),
    .dout(uns_dout), .dout_ovf(uns_ovf));

  // Directed vector with hand-computed results for every instance.
  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  b;
    logic [31:0] def_r;
    logic        def_o;
    logic [15:0] sat_r;
    logic [15:0] trn_r;
    logic        o16;
    logic [31:0] uns_r;
    logic        uns_o;
  } vec_t;

  vec_t        vecs [N_DIR];
  logic [31:0] rnd_a [N_RND];
  logic [7:0]  rnd_b [N_RND];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] b,
                       input logic rdy);
    din_valid  = v;
    din0       = a;
    din1       = b;
    dout_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: exact 64-bit arithmetic, then range test against the result type.
  function automatic void model(input logic [31:0] a, input logic [7:0] b, input int dw,
                                input bit s0, input bit s1, input bit sat,
                                output logic [31:0] r, output logic o);
    longint va, vb, p, mx, mn, mask;
    va = s0 ? longint'($signed(a)) : longint'(a);
    vb = s1 ? longint'($signed(b)) : longint'(b);
    p  = va * vb;
    if (s0 || s1) begin
      mx = (longint'(1) << (dw - 1)) - 1;
      mn = -(longint'(1) << (dw - 1));
    end else begin
      mx = (longint'(1) << dw) - 1;
      mn = 0;
    end
    o = (p > mx) || (p < mn);
    if (sat && o) p = (p > mx) ? mx : mn;
    mask = (longint'(1) << dw) - 1;
    r = 32'(p & mask);
  endfunction

  // One handshake cycle of the backpressure scenario on u_def.
  task automatic stall_step(input logic v, input logic [31:0] a, input logic [7:0] b,
                            input logic rdy, input logic e_rdy, input logic e_vld,
                            input logic [31:0] e_dout, input logic e_ovf);
    drive(v, a, b, rdy);
    @(negedge ap_clk);
    check("bp_din_ready", def_rdy, e_rdy);
    check("bp_dout_valid", def_vld, e_vld);
    if (e_vld) begin
      check("bp_dout", def_dout, e_dout);
      check("bp_dout_ovf", def_ovf, e_ovf);
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic        eo;
    int          k;

    //               a             b      def_r         o  sat_r     trn_r    o16 uns_r         o
    vecs[0]  = '{32'hFFFFFFFB, 8'd200, 32'hFFFFFC18, 1'b0, 16'hFC18, 16'hFC18, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[1]  = '{32'h00010000, 8'd2,   32'h00020000, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 32'h00020000, 1'b0};
    vecs[2]  = '{32'hFFFF0000, 8'd2,   32'hFFFE0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{32'h00007FFF, 8'd1,   32'h00007FFF, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 32'h00007FFF, 1'b0};
    vecs[4]  = '{32'h00004000, 8'd2,   32'h00008000, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 32'h00008000, 1'b0};
    vecs[5]  = '{32'hFFFF8000, 8'd1,   32'hFFFF8000, 1'b0, 16'h8000, 16'h8000, 1'b0, 32'hFFFF8000, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 8'hFF,  32'hFFFFFF01, 1'b0, 16'hFF01, 16'hFF01, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{32'h7FFFFFFF, 8'hFF,  32'h7FFFFF01, 1'b1, 16'h7FFF, 16'hFF01, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{32'h80000000, 8'd1,   32'h80000000, 1'b0, 16'h8000, 16'h0000, 1'b1, 32'h80000000, 1'b0};
    vecs[9]  = '{32'h80000000, 8'd2,   32'h00000000, 1'b1, 16'h8000, 16'h0000, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{32'h00000000, 8'hFF,  32'h00000000, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h00000000, 1'b0};

    // ---------------- reset state ----------------
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_def_valid", def_vld, 1'b0);
    check("rst_def_dout", def_dout, 32'h0);
    check("rst_def_ovf", def_ovf, 1'b0);
    check("rst_din_ready", def_rdy, 1'b1);
    check("rst_sat_valid", sat_vld, 1'b0);
    check("rst_uns_valid", uns_vld, 1'b0);
    next_cycle();
    next_cycle();
    ap_rst_n = 1'b1;

    // ---------------- directed stream, dout_ready=1 ----------------
    // Vector j is driven in cycle j and must appear exactly in cycle j+2.
    for (int j = 0; j < N_DIR + 3; j++) begin
      if (j < N_DIR) drive(1'b1, vecs[j].a, vecs[j].b, 1'b1);
      else           drive(1'b0, 32'h0, 8'h0, 1'b1);
      @(negedge ap_clk);
      if (j >= 2 && j - 2 < N_DIR) begin
        k = j - 2;
        check($sformatf("dir%0d_def_valid", k), def_vld, 1'b1);
        check($sformatf("dir%0d_def_dout", k), def_dout, vecs[k].def_r);
        check($sformatf("dir%0d_def_ovf", k), def_ovf, vecs[k].def_o);
        check($sformatf("dir%0d_sat_dout", k), sat_dout, vecs[k].sat_r);
        check($sformatf("dir%0d_sat_ovf", k), sat_ovf, vecs[k].o16);
        check($sformatf("dir%0d_trn_dout", k), trn_dout, vecs[k].trn_r);
        check($sformatf("dir%0d_trn_ovf", k), trn_ovf, vecs[k].o16);
        check($sformatf("dir%0d_uns_valid", k), uns_vld, 1'b1);
        check($sformatf("dir%0d_uns_dout", k), uns_dout, vecs[k].uns_r);
        check($sformatf("dir%0d_uns_ovf", k), uns_ovf, vecs[k].uns_o);
      end else begin
        check($sformatf("dir_idle%0d_valid", j), def_vld, 1'b0);
      end
      next_cycle();
    end

    // ---------------- backpressure ----------------
    // A, B, C back to back; A drains, then 5 stall cycles hold B while D waits.
    stall_step(1'b1, vecs[0].a, vecs[0].b, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    stall_step(1'b1, vecs[1].a, vecs[1].b, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    stall_step(1'b1, vecs[3].a, vecs[3].b, 1'b1, 1'b1, 1'b1, vecs[0].def_r, vecs[0].def_o);
    for (int s = 0; s < 5; s++)
      stall_step(1'b1, vecs[7].a, vecs[7].b, 1'b0, 1'b0, 1'b1, vecs[1].def_r, vecs[1].def_o);
    stall_step(1'b1, vecs[7].a, vecs[7].b, 1'b1, 1'b1, 1'b1, vecs[1].def_r, vecs[1].def_o);
    stall_step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b1, vecs[3].def_r, vecs[3].def_o);
    stall_step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b1, vecs[7].def_r, vecs[7].def_o);
    stall_step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    stall_step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // ---------------- reset with two results in flight ----------------
    drive(1'b1, vecs[7].a, vecs[7].b, 1'b1);
    next_cycle();
    drive(1'b1, vecs[1].a, vecs[1].b, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    @(negedge ap_clk);
    check("mid_inflight_valid", def_vld, 1'b1);
    check("mid_inflight_ovf", def_ovf, 1'b1);
    #1 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", def_vld, 1'b0);
    check("mid_rst_dout", def_dout, 32'h0);
    check("mid_rst_ovf", def_ovf, 1'b0);
    check("mid_rst_sat_valid", sat_vld, 1'b0);
    next_cycle();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      check($sformatf("post_rst%0d_valid", c), def_vld, 1'b0);
      check($sformatf("post_rst%0d_din_ready", c), def_rdy, 1'b1);
      next_cycle();
    end

    // ---------------- throughput, 100 random pairs ----------------
    for (int i = 0; i < N_RND; i++) begin
      rnd_a[i] = $urandom;
      rnd_b[i] = 8'($urandom_range(0, 255));
    end
    for (int j = 0; j < N_RND + 2; j++) begin
      if (j < N_RND) drive(1'b1, rnd_a[j], rnd_b[j], 1'b1);
      else           drive(1'b0, 32'h0, 8'h0, 1'b1);
      @(negedge ap_clk);
      if (j >= 2) begin
        k = j - 2;
        check($sformatf("rnd%0d_def_valid", k), def_vld, 1'b1);
        model(rnd_a[k], rnd_b[k], 32, 1'b1, 1'b0, 1'b0, er, eo);
        check($sformatf("rnd%0d_def_dout", k), def_dout, er);
        check($sformatf("rnd%0d_def_ovf", k), def_ovf, eo);
        model(rnd_a[k], rnd_b[k], 16, 1'b1, 1'b0, 1'b1, er, eo);
        check($sformatf("rnd%0d_sat_dout", k), sat_dout, er);
        check($sformatf("rnd%0d_sat_ovf", k), sat_ovf, eo);
        model(rnd_a[k], rnd_b[k], 16, 1'b1, 1'b0, 1'b0, er, eo);
        check($sformatf("rnd%0d_trn_dout", k), trn_dout, er);
        check($sformatf("rnd%0d_trn_ovf", k), trn_ovf, eo);
        model(rnd_a[k], rnd_b[k], 32, 1'b0, 1'b0, 1'b1, er, eo);
        check($sformatf("rnd%0d_uns_dout", k), uns_dout, er);
        check($sformatf("rnd%0d_uns_ovf", k), uns_ovf, eo);
      end else begin
        check($sformatf("rnd_lead%0d_valid", j), def_vld, 1'b0);
      end
      next_cycle();
    end
    @(negedge ap_clk);
    check("rnd_tail_valid", def_vld, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fpga_test_step_mul_pipe
